multibyte_sub_seq: RTL and testbench
====================================

MULTIBYTE_SUB_SEQ -- requirements
Module: multibyte_sub_seq

Interface
REQ-001 Parameter: NBYTES, 4, operand width in bytes; legal range 1..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset is asynchronous and active-low.
REQ-004 in_valid  in  1  operand set presented.
REQ-005 in_ready  out  1  block accepts an operand set this cycle.
REQ-006 in_A  in  8*NBYTES  minuend, unsigned.
REQ-007 in_B  in  8*NBYTES  subtrahend, unsigned.
REQ-008 in_Bin  in  1  borrow-in.
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  consumer takes result this cycle.
REQ-011 out_Diff  out  8*NBYTES  difference.
REQ-012 out_Bout  out  1  final borrow-out.
REQ-013 busy  out  1  high in RUN or DONE.

Function
REQ-014 The block SHALL instantiate exactly one 8-bit ripple-carry subtractor RCS (ports rs_A, rs_B, rs_Bin, rs_Diff, rs_Bout) and process one byte per cycle, LSB byte first.
REQ-015 FSM states SHALL be IDLE, RUN and DONE, with binary encoding and default branch returning to IDLE.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL latch in_A, in_B, load borrow register with in_Bin, clear byte index and go to RUN.
REQ-017 RUN: each cycle the block SHALL drive rs_A/rs_B with byte[idx] of the latched operands and rs_Bin with the borrow register, write rs_Diff into result byte[idx], load borrow register with rs_Bout and increment idx.
REQ-018 RUN SHALL transition to DONE on the edge that processes idx==NBYTES-1.
REQ-019 DONE: out_valid=1; out_Diff and out_Bout SHALL hold stable until out_valid&&out_ready, then go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid, in_A, in_B and in_Bin SHALL be ignored outside IDLE.
REQ-021 Latency: out_valid SHALL rise exactly NBYTES cycles after the acceptance edge; minimum operation period SHALL be NBYTES+2 cycles.
REQ-022 Arithmetic: out_Diff SHALL equal (A - B - Bin) mod 2^(8*NBYTES); out_Bout SHALL be 1 iff A < B + Bin (unsigned).
REQ-023 out_Diff and out_Bout SHALL retain the last result in IDLE until the next DONE overwrites them.
REQ-024 NBYTES=1 SHALL give one RUN cycle and identical arithmetic rules.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, idx=0, borrow register=0, out_Diff=0, out_Bout=0, out_valid=0, busy=0, in_ready=1.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation with no partial result emitted.
REQ-027 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification (NBYTES=4)
REQ-028 A=0x00000002, B=0x00000001, Bin=1 -> out_Diff=0x00000000, out_Bout=0, out_valid exactly 4 cycles after accept.
REQ-029 A=0x00000007, B=0x00000004, Bin=1 -> out_Diff=0x00000002, out_Bout=0.
REQ-030 A=0x00000100, B=0x00000001, Bin=0 -> out_Diff=0x000000FF, out_Bout=0 (borrow crosses byte boundary).
REQ-031 A=0x00000000, B=0x00000000, Bin=1 -> out_Diff=0xFFFFFFFF, out_Bout=1 (full wrap).
REQ-032 Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> out_valid stays 1, out_Diff/out_Bout stable, in_ready=0, no new operand accepted; out_ready=1 -> IDLE next edge.
REQ-033 rst_n low during RUN at idx=2 -> out_valid=0, in_ready=1 at once; after release, A=0x12345678, B=0x11111111, Bin=0 -> out_Diff=0x01234567, out_Bout=0.

Source files
------------

// File: rtl/multibyte_sub_seq.sv
// -----------------------------------------------------------------------------
// multibyte_sub_seq
//   Byte-serial unsigned subtractor. An operand set (A, B, borrow-in) is
//   accepted in IDLE, then one shared 8-bit ripple-borrow subtractor processes
//   one byte per cycle, LSB byte first. The full difference and final
//   borrow-out are presented in DONE until the consumer takes them.
//
//   rcs               8-bit ripple-borrow subtractor (one instance in the top)
//
// Ports (multibyte_sub_seq):
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand set presented
//   in_ready   out  operand set accepted this cycle (IDLE only)
//   in_A       in   minuend, 8*NBYTES bits, unsigned
//   in_B       in   subtrahend, 8*NBYTES bits, unsigned
//   in_Bin     in   borrow-in
//   out_valid  out  result available (DONE)
//   out_ready  in   consumer takes result this cycle
//   out_Diff   out  difference, 8*NBYTES bits
//   out_Bout   out  final borrow-out
//   busy       out  high in RUN or DONE
// -----------------------------------------------------------------------------

module rcs (
  input  logic [7:0] rs_A,
  input  logic [7:0] rs_B,
  input  logic       rs_Bin,
  output logic [7:0] rs_Diff,
  output logic       rs_Bout
);

  // w_brw[i] is the borrow into bit i
  logic [8:0] w_brw;

  assign w_brw[0] = rs_Bin;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign rs_Diff[gi]  = rs_A[gi] ^ rs_B[gi] ^ w_brw[gi];
    // Borrow out when a<b, or a==b and a borrow comes in
    assign w_brw[gi+1]  = (~rs_A[gi] & rs_B[gi]) | (~(rs_A[gi] ^ rs_B[gi]) & w_brw[gi]);
  end

  assign rs_Bout = w_brw[8];

endmodule

module multibyte_sub_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_A,
  input  logic [8*NBYTES-1:0]   in_B,
  input  logic                  in_Bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_Diff,
  output logic                  out_Bout,
  output logic                  busy
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e          r_state;
  state_e          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;     // working result, filled byte by byte
  logic [W-1:0]    r_diff;    // presented result, only updated on entry to DONE
  logic            r_bout;
  logic            r_borrow;
  logic [IdxW-1:0] r_idx;

  logic            w_accept;
  logic            w_last;
  logic [31:0]     w_bit;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_rs_diff;
  logic            w_rs_bout;
  logic [W-1:0]    w_res_next;

  // ---------------------------------------------------------------------------
  // Handshake and byte selection
  // ---------------------------------------------------------------------------
  assign w_accept = in_valid && (r_state == StIdle);
  assign w_last   = (r_idx == IdxW'(NBYTES - 1));
  assign w_bit    = 32'(r_idx) << 3;
  assign w_a_byte = r_a[w_bit +: 8];
  assign w_b_byte = r_b[w_bit +: 8];

  rcs u_rcs (
    .rs_A    (w_a_byte),
    .rs_B    (w_b_byte),
    .rs_Bin  (r_borrow),
    .rs_Diff (w_rs_diff),
    .rs_Bout (w_rs_bout)
  );

  // Working result with the current byte merged in
  always_comb begin
    w_res_next             = r_res;
    w_res_next[w_bit +: 8] = w_rs_diff;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_next = StRun;
      StRun:  if (w_last)   w_state_next = StDone;
      StDone: if (out_ready) w_state_next = StIdle;
      default:               w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a      <= in_A;
            r_b      <= in_B;
            r_res    <= '0;
            r_borrow <= in_Bin;
            r_idx    <= '0;
          end
        end
        StRun: begin
          r_res    <= w_res_next;
          r_borrow <= w_rs_bout;
          if (w_last) begin
            r_idx  <= '0;
            r_diff <= w_res_next;
            r_bout <= w_rs_bout;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign out_Diff  = r_diff;
  assign out_Bout  = r_bout;

endmodule

// File: tb/tb_multibyte_sub_seq.sv
// -----------------------------------------------------------------------------
// tb_multibyte_sub_seq
//   Directed bench for multibyte_sub_seq with NBYTES=4. Inputs are driven 1ns
//   after the rising edge (or at the falling edge), outputs sampled likewise.
// -----------------------------------------------------------------------------

module tb_multibyte_sub_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         in_Bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_Diff;
  logic         out_Bout;
  logic         busy;

  int n_cmp;
  int n_err;

  multibyte_sub_seq #(
    .NBYTES (NB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_A      (in_A),
    .in_B      (in_B),
    .in_Bin    (in_Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_Diff  (out_Diff),
    .out_Bout  (out_Bout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set now, expect acceptance on the next edge, then
  // check latency and result. With hold > 0, out_ready stays low that many
  // cycles in DONE while in_valid is pulsed with unrelated operands.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] exp_d, input logic exp_bo,
                       input int hold);
    int lat;
    in_A     = a;
    in_B     = b;
    in_Bin   = bin;
    in_valid = 1'b1;
    check({tag, ".in_ready_idle"}, W'(in_ready), W'(1'b1));
    step();
    in_valid = 1'b0;
    in_A     = '0;
    in_B     = '0;
    in_Bin   = 1'b0;
    check({tag, ".busy_run"}, W'(busy), W'(1'b1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, W'(lat), W'(NB));
    check({tag, ".diff"}, out_Diff, exp_d);
    check({tag, ".bout"}, W'(out_Bout), W'(exp_bo));
    check({tag, ".in_ready_done"}, W'(in_ready), W'(1'b0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_A     = 32'hDEAD_BEEF;
      in_B     = 32'h0000_0001;
      in_Bin   = 1'b1;
      step();
      in_valid = 1'b0;
      check({tag, ".hold_valid"}, W'(out_valid), W'(1'b1));
      check({tag, ".hold_diff"}, out_Diff, exp_d);
      check({tag, ".hold_bout"}, W'(out_Bout), W'(exp_bo));
      check({tag, ".hold_in_ready"}, W'(in_ready), W'(1'b0));
    end
    in_A      = '0;
    in_B      = '0;
    in_Bin    = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, W'(out_valid), W'(1'b0));
    check({tag, ".idle_busy"}, W'(busy), W'(1'b0));
    check({tag, ".idle_in_ready"}, W'(in_ready), W'(1'b1));
    check({tag, ".retain_diff"}, out_Diff, exp_d);
    check({tag, ".retain_bout"}, W'(out_Bout), W'(exp_bo));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_A      = '0;
    in_B      = '0;
    in_Bin    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst.in_ready", W'(in_ready), W'(1'b1));
    check("rst.out_valid", W'(out_valid), W'(1'b0));
    check("rst.busy", W'(busy), W'(1'b0));
    check("rst.diff", out_Diff, '0);
    check("rst.bout", W'(out_Bout), W'(1'b0));

    // Release at t=22; first operand accepted on the very next edge (t=25)
    #10;
    rst_n = 1'b1;
    do_op("v1", 32'h0000_0002, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0, 0);
    do_op("v2", 32'h0000_0007, 32'h0000_0004, 1'b1, 32'h0000_0002, 1'b0, 0);
    do_op("v3", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 0);
    do_op("v4", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    do_op("v5", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 0);
    do_op("v6", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, 0);
    do_op("v7", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);

    // Backpressure in DONE with in_valid pulsing
    do_op("hold", 32'h0000_1000, 32'h0000_0FFF, 1'b1, 32'h0000_0000, 1'b0, 5);
    // Stray in_valid pulses in DONE must not have started a new operation
    step();
    check("hold.no_accept_busy", W'(busy), W'(1'b0));
    check("hold.no_accept_diff", out_Diff, 32'h0000_0000);

    // Leave a non-zero result so reset clearing is visible
    do_op("pre_rst", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 0);

    // Abort in RUN at idx=2
    in_A     = 32'hAAAA_AAAA;
    in_B     = 32'h5555_5555;
    in_Bin   = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("abort.busy_before", W'(busy), W'(1'b1));
    check("abort.valid_before", W'(out_valid), W'(1'b0));
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", W'(out_valid), W'(1'b0));
    check("abort.in_ready", W'(in_ready), W'(1'b1));
    check("abort.busy", W'(busy), W'(1'b0));
    check("abort.diff", out_Diff, '0);
    check("abort.bout", W'(out_Bout), W'(1'b0));
    #3;
    rst_n = 1'b1;
    do_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
